id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 119 +++++++++++
 tb/tb_id_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction decode with register file, branch resolution and ID/EX pipeline registers
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [63:0] PC,
  input  logic [63:0] WriteData,
  input  logic [4:0]  WriteRegister,
  input  logic        RegWriteWB,
  input  logic        Reg2Loc,
  input  logic        LinkerReg,
  input  logic        Uncondbranch,
  input  logic        Branch,
  input  logic        ZeroBranch,
  input  logic        BranchToReg,
  input  logic        IType,
  input  logic        RType,
  input  logic        LTFlagEx,
  input  logic        ALUZeroFlagFromEx,
  input  logic        ZeroBranchForwarding,
  input  logic        RegWriteCtrl,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        SetFlags,
  input  logic        ALUSrc,
  input  logic        Store,
  input  logic [2:0]  ALUOp,
  output logic [63:0] realBranchingAddr,
  output logic        BrTaken,
  output logic [4:0]  Rm_curr,
  output logic [4:0]  RdIdEx,
  output logic [4:0]  RmReg,
  output logic [4:0]  RnReg,
  output logic [63:0] RData1Reg,
  output logic [63:0] RData2Reg,
  output logic [63:0] ImmOrDest,
  output logic [63:0] LinkerRegisterData,
  output logic        RegWriteRegister,
  output logic        MemReadRegister,
  output logic        MemWriteRegister,
  output logic        MemToRegRegister,
  output logic        SetFlagsRegister,
  output logic        ALUSrcRegisterID,
  output logic        StoreReg,
  output logic        LinkerRegIdEx,
  output logic [2:0]  ALUOpRegister
);
  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];
  logic [4:0]  rn, rm, rd;
  logic [63:0] rdata1, rdata2, offset, branch_pc, imm;
  logic        real_zero, cond_br;
  logic [14:0] idx_d, idx_q;
  logic [10:0] ctrl_d, ctrl_q;
  logic [63:0] rdata1_d, rdata1_q, rdata2_d, rdata2_q, imm_d, imm_q, link_d, link_q;
  logic        unused_opcode;
  assign unused_opcode = ^instruction[31:26];
  // write-back update; entry 31 is never written so X31 stays zero
  always_comb begin
    regs_d = regs_q;
    if (RegWriteWB && WriteRegister != 5'd31) regs_d[WriteRegister] = WriteData;
  end
  // register file captures on the falling edge so the same cycle's read sees the new value
  always_ff @(negedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end
  // decode, branch target/decision and immediate selection
  always_comb begin
    rn = instruction[9:5];
    rm = Reg2Loc ? instruction[20:16] : instruction[4:0];
    rd = LinkerReg ? 5'd30 : instruction[4:0];
    rdata1 = regs_q[rn];
    rdata2 = regs_q[rm];
    offset = (Uncondbranch ? {{38{instruction[25]}}, instruction[25:0]}
                           : {{45{instruction[23]}}, instruction[23:5]}) << 2;
    branch_pc = PC + offset;
    real_zero = ZeroBranchForwarding ? ALUZeroFlagFromEx : (rdata2 == 64'd0);
    cond_br = ZeroBranch ? real_zero : LTFlagEx;
    imm = IType ? {52'd0, instruction[21:10]}
        : RType ? {58'd0, instruction[15:10]}
        : {{55{instruction[20]}}, instruction[20:12]};
    idx_d = {rd, rm, rn};
    ctrl_d = {RegWriteCtrl, MemRead, MemWrite, MemToReg, SetFlags, ALUSrc, Store, LinkerReg, ALUOp};
    rdata1_d = rdata1;
    rdata2_d = rdata2;
    imm_d = imm;
    link_d = PC + 64'd4;
  end
  assign realBranchingAddr = BranchToReg ? rdata2 : branch_pc;
  assign BrTaken = (Branch & cond_br) | Uncondbranch;
  assign Rm_curr = rd;
  // ID/EX pipeline registers, one-cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      ctrl_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q <= '0;
      link_q <= '0;
    end else begin
      idx_q <= idx_d;
      ctrl_q <= ctrl_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q <= imm_d;
      link_q <= link_d;
    end
  end
  assign {RdIdEx, RmReg, RnReg} = idx_q;
  assign {RegWriteRegister, MemReadRegister, MemWriteRegister, MemToRegRegister, SetFlagsRegister,
          ALUSrcRegisterID, StoreReg, LinkerRegIdEx, ALUOpRegister} = ctrl_q;
  assign RData1Reg = rdata1_q;
  assign RData2Reg = rdata2_q;
  assign ImmOrDest = imm_q;
  assign LinkerRegisterData = link_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of decode, register file, branch logic and pipeline registers
module tb_id_stage;
  logic        clk = 0;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] PC, WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWriteWB, Reg2Loc, LinkerReg, Uncondbranch, Branch, ZeroBranch, BranchToReg, IType, RType;
  logic        LTFlagEx, ALUZeroFlagFromEx, ZeroBranchForwarding;
  logic        RegWriteCtrl, MemRead, MemWrite, MemToReg, SetFlags, ALUSrc, Store;
  logic [2:0]  ALUOp;
  logic [63:0] realBranchingAddr, RData1Reg, RData2Reg, ImmOrDest, LinkerRegisterData;
  logic        BrTaken, RegWriteRegister, MemReadRegister, MemWriteRegister, MemToRegRegister;
  logic        SetFlagsRegister, ALUSrcRegisterID, StoreReg, LinkerRegIdEx;
  logic [4:0]  Rm_curr, RdIdEx, RmReg, RnReg;
  logic [2:0]  ALUOpRegister;
  int tests = 0, fails = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PC(PC), .WriteData(WriteData),
    .WriteRegister(WriteRegister), .RegWriteWB(RegWriteWB), .Reg2Loc(Reg2Loc), .LinkerReg(LinkerReg),
    .Uncondbranch(Uncondbranch), .Branch(Branch), .ZeroBranch(ZeroBranch), .BranchToReg(BranchToReg),
    .IType(IType), .RType(RType), .LTFlagEx(LTFlagEx), .ALUZeroFlagFromEx(ALUZeroFlagFromEx),
    .ZeroBranchForwarding(ZeroBranchForwarding), .RegWriteCtrl(RegWriteCtrl), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .SetFlags(SetFlags), .ALUSrc(ALUSrc), .Store(Store),
    .ALUOp(ALUOp), .realBranchingAddr(realBranchingAddr), .BrTaken(BrTaken), .Rm_curr(Rm_curr),
    .RdIdEx(RdIdEx), .RmReg(RmReg), .RnReg(RnReg), .RData1Reg(RData1Reg), .RData2Reg(RData2Reg),
    .ImmOrDest(ImmOrDest), .LinkerRegisterData(LinkerRegisterData), .RegWriteRegister(RegWriteRegister),
    .MemReadRegister(MemReadRegister), .MemWriteRegister(MemWriteRegister),
    .MemToRegRegister(MemToRegRegister), .SetFlagsRegister(SetFlagsRegister),
    .ALUSrcRegisterID(ALUSrcRegisterID), .StoreReg(StoreReg), .LinkerRegIdEx(LinkerRegIdEx),
    .ALUOpRegister(ALUOpRegister)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    {RegWriteWB, Reg2Loc, LinkerReg, Uncondbranch, Branch, ZeroBranch, BranchToReg, IType, RType} = '0;
    {LTFlagEx, ALUZeroFlagFromEx, ZeroBranchForwarding} = '0;
    {RegWriteCtrl, MemRead, MemWrite, MemToReg, SetFlags, ALUSrc, Store} = '0;
    ALUOp = '0;
    WriteRegister = '0;
    WriteData = '0;
  endtask

  initial begin
    reset = 1;
    instruction = '0;
    PC = '0;
    clear_ctrl();
    RegWriteCtrl = 1;
    ALUOp = 3'b111;
    PC = 64'h100;
    step();
    step();
    chk("reset_rdata1", RData1Reg, 0);
    chk("reset_link", LinkerRegisterData, 0);
    chk("reset_regwrite", RegWriteRegister, 0);
    chk("reset_aluop", ALUOpRegister, 0);
    reset = 0;
    clear_ctrl();
    // write X4=160 while reading it through Rn in the same cycle
    instruction = 32'h0000_0080;
    RegWriteWB = 1; WriteRegister = 4; WriteData = 160;
    step();
    chk("wbr_rdata1", RData1Reg, 160);
    chk("wbr_rn", RnReg, 4);
    // X5 = 0x400
    WriteRegister = 5; WriteData = 64'h400;
    step();
    RegWriteWB = 0;
    // ADDI X0,X31,#0
    instruction = 32'h910003E0; IType = 1; PC = 64'h40;
    step();
    chk("addi_rn", RnReg, 31);
    chk("addi_rdata1", RData1Reg, 0);
    chk("addi_imm", ImmOrDest, 0);
    chk("addi_rd", RdIdEx, 0);
    chk("addi_link", LinkerRegisterData, 64'h44);
    IType = 0;
    // B with imm26 = -1 from PC 12
    instruction = 32'h17FFFFFF; PC = 12; Uncondbranch = 1;
    #1;
    chk("b_taken", BrTaken, 1);
    chk("b_target", realBranchingAddr, 8);
    Uncondbranch = 0;
    // CBZ imm19=3, Rt=X7 (zero) from PC 100
    instruction = 32'hB4000067; PC = 100; Branch = 1; ZeroBranch = 1;
    #1;
    chk("cbz_taken", BrTaken, 1);
    chk("cbz_target", realBranchingAddr, 112);
    instruction = 32'hB4000064;
    #1;
    chk("cbz_nonzero", BrTaken, 0);
    ZeroBranchForwarding = 1; ALUZeroFlagFromEx = 1;
    #1;
    chk("cbz_fwd", BrTaken, 1);
    ALUZeroFlagFromEx = 0;
    #1;
    chk("cbz_fwd0", BrTaken, 0);
    ZeroBranchForwarding = 0; ZeroBranch = 0; LTFlagEx = 1;
    #1;
    chk("blt_taken", BrTaken, 1);
    Branch = 0;
    #1;
    chk("no_branch", BrTaken, 0);
    LTFlagEx = 0;
    // BL then BR
    LinkerReg = 1; Uncondbranch = 1; instruction = 32'h94000003; PC = 64'h200;
    #1;
    chk("bl_rm_curr", Rm_curr, 30);
    step();
    chk("bl_rd", RdIdEx, 30);
    chk("bl_linkflag", LinkerRegIdEx, 1);
    chk("bl_link", LinkerRegisterData, 64'h204);
    LinkerReg = 0; Uncondbranch = 0;
    instruction = 32'h0000_0005; BranchToReg = 1;
    #1;
    chk("br_target", realBranchingAddr, 64'h400);
    BranchToReg = 0;
    // Reg2Loc read index, RType immediate, controls
    instruction = 32'h0009_A885; Reg2Loc = 1; RType = 1;
    RegWriteCtrl = 1; MemWrite = 1; Store = 1; ALUOp = 3'b101;
    step();
    chk("r2l_rm", RmReg, 9);
    chk("rtype_imm", ImmOrDest, 42);
    chk("r2l_rdata1", RData1Reg, 160);
    chk("ctrl_regwrite", RegWriteRegister, 1);
    chk("ctrl_memwrite", MemWriteRegister, 1);
    chk("ctrl_memread", MemReadRegister, 0);
    chk("ctrl_store", StoreReg, 1);
    chk("ctrl_aluop", ALUOpRegister, 3'b101);
    // D-type negative offset, read port 2 through Rt=X5
    Reg2Loc = 0; RType = 0; instruction = 32'h001F_F005;
    RegWriteCtrl = 0; MemWrite = 0; Store = 0; MemRead = 1; ALUOp = 3'b010;
    step();
    chk("dtype_imm", ImmOrDest, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rdata2", RData2Reg, 64'h400);
    chk("ctrl_memread2", MemReadRegister, 1);
    // asynchronous reset between edges
    #2 reset = 1;
    #1;
    chk("async_rdata2", RData2Reg, 0);
    chk("async_memread", MemReadRegister, 0);
    chk("async_imm", ImmOrDest, 0);
    instruction = 32'h0000_0004; BranchToReg = 1;
    #1;
    chk("async_regfile", realBranchingAddr, 0);
    BranchToReg = 0;
    step();
    reset = 0;
    // write X31 then read it back
    RegWriteWB = 1; WriteRegister = 31; WriteData = 64'hDEAD;
    step();
    RegWriteWB = 0;
    instruction = 32'h0000_03E0;
    step();
    chk("x31_zero", RData1Reg, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
